// File: rtl/bram_pkg.sv
// Shared types and constants for the BRAM arbiter: FSM state encoding, read latency, default widths.
package bram_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2
   } bram_state_e;

   localparam int unsigned BRAM_RD_LATENCY = 2;
   localparam int unsigned DEFAULT_ADDR_W  = 19;
   localparam int unsigned DEFAULT_DATA_W  = 8;

   function automatic bram_state_e other_state(input bram_state_e s);
      unique case (s)
         RD:      return WR;
         WR:      return RD;
         default: return IDLE;
      endcase
   endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Read-return delay line: re-times read grants by the BRAM latency and gates the returned data.
module bram_rd_pipe
   import bram_pkg::*;
#(
   parameter int unsigned DATA_W  = DEFAULT_DATA_W,
   parameter int unsigned LATENCY = BRAM_RD_LATENCY
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              gnt_i,
   input  logic [DATA_W-1:0] mem2d_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o
);

   logic [LATENCY-1:0] vld_q, vld_d;

   always_comb begin
      vld_d    = '0;
      vld_d[0] = gnt_i;
      for (int i = 1; i < LATENCY; i++) begin
         vld_d[i] = vld_q[i-1];
      end
   end

   // Reset flushes in-flight returns so no stale valid escapes after an abort.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
      end else begin
         vld_q <= vld_d;
      end
   end

   assign valid_o = vld_q[LATENCY-1];
   assign data_o  = valid_o ? mem2d_i : '0;

endmodule

// File: rtl/bram_arbiter.sv
// Round-robin burst arbiter sharing one BRAM port between a read and a write requester.
// Optional beat statistics outputs are enabled with BRAM_ARBITER_STATS_EN.
module bram_arbiter
   import bram_pkg::*;
#(
   parameter int unsigned ADDR_W    = DEFAULT_ADDR_W,
   parameter int unsigned DATA_W    = DEFAULT_DATA_W,
   parameter int unsigned BURST_LEN = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_req_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic              rd_gnt_o,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              rd_valid_o,
   input  logic              wr_req_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   output logic              wr_gnt_o,
   output logic              ena_o,
   output logic              wea_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] d2mem_o,
   input  logic [DATA_W-1:0] mem2d_i
`ifdef BRAM_ARBITER_STATS_EN
   ,
   output logic [31:0]       rd_beats_o,
   output logic [31:0]       wr_beats_o
`endif
);

   localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

   bram_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last_wr_q, last_wr_d;
   logic             rearm_q, rearm_d;

   logic rd_gnt, wr_gnt, own_gnt;
   logic own_req, other_req, burst_end;

   always_comb begin
      rd_gnt    = 1'b0;
      wr_gnt    = 1'b0;
      own_req   = 1'b0;
      other_req = 1'b0;
      unique case (state_q)
         RD: begin
            rd_gnt    = rd_req_i & ~rearm_q;
            own_req   = rd_req_i;
            other_req = wr_req_i;
         end
         WR: begin
            wr_gnt    = wr_req_i & ~rearm_q;
            own_req   = wr_req_i;
            other_req = rd_req_i;
         end
         default: ;
      endcase
   end

   assign own_gnt   = rd_gnt | wr_gnt;
   assign burst_end = (state_q != IDLE) && !rearm_q &&
                      (!own_req || (own_gnt && cnt_q == CNT_W'(BURST_LEN - 1)));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_wr_d = last_wr_q;
      rearm_d   = 1'b0;
      if (state_q == IDLE) begin
         cnt_d = '0;
         if (rd_req_i && wr_req_i) begin
            state_d = last_wr_q ? RD : WR;
         end else if (rd_req_i) begin
            state_d = RD;
         end else if (wr_req_i) begin
            state_d = WR;
         end
      end else if (rearm_q) begin
         // One idle beat after a full burst with no competitor, then resume or hand over.
         cnt_d = '0;
         if (other_req) begin
            state_d = other_state(state_q);
         end else if (!own_req) begin
            state_d = IDLE;
         end
      end else if (burst_end) begin
         cnt_d     = '0;
         last_wr_d = (state_q == WR);
         if (other_req) begin
            state_d = other_state(state_q);
         end else if (!own_req) begin
            state_d = IDLE;
         end else begin
            rearm_d = 1'b1;
         end
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         last_wr_q <= 1'b1;
         rearm_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_wr_q <= last_wr_d;
         rearm_q   <= rearm_d;
      end
   end

   assign rd_gnt_o = rd_gnt;
   assign wr_gnt_o = wr_gnt;
   assign ena_o    = own_gnt;
   assign wea_o    = wr_gnt;
   assign addr_o   = rd_gnt ? rd_addr_i : (wr_gnt ? wr_addr_i : '0);
   assign d2mem_o  = wr_gnt ? wr_data_i : '0;

   bram_rd_pipe #(
      .DATA_W  (DATA_W),
      .LATENCY (BRAM_RD_LATENCY)
   ) u_rd_pipe (
      .clk     (clk),
      .rst     (rst),
      .gnt_i   (rd_gnt),
      .mem2d_i (mem2d_i),
      .valid_o (rd_valid_o),
      .data_o  (rd_data_o)
   );

`ifdef BRAM_ARBITER_STATS_EN
   logic [31:0] rd_beats_q, rd_beats_d;
   logic [31:0] wr_beats_q, wr_beats_d;

   always_comb begin
      rd_beats_d = rd_beats_q + {31'd0, rd_gnt};
      wr_beats_d = wr_beats_q + {31'd0, wr_gnt};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_beats_q <= '0;
         wr_beats_q <= '0;
      end else begin
         rd_beats_q <= rd_beats_d;
         wr_beats_q <= wr_beats_d;
      end
   end

   assign rd_beats_o = rd_beats_q;
   assign wr_beats_o = wr_beats_q;
`endif

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: directed scenarios plus random traffic against a burst model.
module tb_bram_arbiter;

   localparam int unsigned ADDR_W    = 19;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned BURST_LEN = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              rd_req, wr_req;
   logic [ADDR_W-1:0] rd_addr, wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              rd_gnt_o, rd_valid_o, wr_gnt_o, ena_o, wea_o;
   logic [DATA_W-1:0] rd_data_o, d2mem_o, mem2d;
   logic [ADDR_W-1:0] addr_o;
`ifdef BRAM_ARBITER_STATS_EN
   logic [31:0]       rd_beats_o, wr_beats_o;
`endif

   always #5 clk = ~clk;

   bram_arbiter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .BURST_LEN (BURST_LEN)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rd_req_i   (rd_req),
      .rd_addr_i  (rd_addr),
      .rd_gnt_o   (rd_gnt_o),
      .rd_data_o  (rd_data_o),
      .rd_valid_o (rd_valid_o),
      .wr_req_i   (wr_req),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .wr_gnt_o   (wr_gnt_o),
      .ena_o      (ena_o),
      .wea_o      (wea_o),
      .addr_o     (addr_o),
      .d2mem_o    (d2mem_o),
      .mem2d_i    (mem2d)
`ifdef BRAM_ARBITER_STATS_EN
      ,
      .rd_beats_o (rd_beats_o),
      .wr_beats_o (wr_beats_o)
`endif
   );

   // Environment: a 256-entry BRAM with 2-cycle read latency driven by the DUT port.
   logic [7:0] bram_mem [256];
   logic [7:0] rdp0;
   always @(posedge clk) begin
      if (ena_o && wea_o) bram_mem[addr_o[7:0]] <= d2mem_o;
      rdp0  <= (ena_o && !wea_o) ? bram_mem[addr_o[7:0]] : 8'h00;
      mem2d <= rdp0;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: who owns the port, how many beats this burst, and whether a
   // full burst just ended with nobody else waiting (one quiet beat follows).
   int         owner;  // 0 none, 1 reader, 2 writer
   int         beats;
   bit         quiet;
   bit         last_wr;
   bit         mv0, mv1;
   logic [7:0] md0, md1;
   logic [7:0] ref_mem [256];
   int         stat_rd, stat_wr;
   bit         m_rd_gnt, m_wr_gnt;
   logic       s_rd_gnt, s_wr_gnt, s_wea, s_rd_valid;
   logic [ADDR_W-1:0] s_addr;
   logic [DATA_W-1:0] s_rd_data;

   task automatic model_reset();
      owner = 0; beats = 0; quiet = 0; last_wr = 1;
      mv0 = 0; mv1 = 0; md0 = '0; md1 = '0;
      stat_rd = 0; stat_wr = 0;
   endtask

   task automatic cycle();
      bit g_rd, g_wr, mine, theirs;
      logic [ADDR_W-1:0] e_addr;
      @(negedge clk);
      g_rd   = (owner == 1) && !quiet && rd_req;
      g_wr   = (owner == 2) && !quiet && wr_req;
      e_addr = g_rd ? rd_addr : (g_wr ? wr_addr : '0);
      check("rd_gnt", 64'(rd_gnt_o), 64'(g_rd));
      check("wr_gnt", 64'(wr_gnt_o), 64'(g_wr));
      check("ena", 64'(ena_o), 64'(g_rd | g_wr));
      check("wea", 64'(wea_o), 64'(g_wr));
      check("addr", 64'(addr_o), 64'(e_addr));
      check("d2mem", 64'(d2mem_o), 64'(g_wr ? wr_data : 8'h00));
      check("rd_valid", 64'(rd_valid_o), 64'(mv1));
      check("rd_data", 64'(rd_data_o), 64'(mv1 ? md1 : 8'h00));
      s_rd_gnt = rd_gnt_o; s_wr_gnt = wr_gnt_o; s_wea = wea_o; s_addr = addr_o;
      s_rd_valid = rd_valid_o; s_rd_data = rd_data_o;
      m_rd_gnt = g_rd; m_wr_gnt = g_wr;
      mv1 = mv0; md1 = md0;
      mv0 = g_rd; md0 = g_rd ? ref_mem[rd_addr[7:0]] : 8'h00;
      if (g_wr) ref_mem[wr_addr[7:0]] = wr_data;
      stat_rd += int'(g_rd); stat_wr += int'(g_wr);
      if (owner == 0) begin
         if (rd_req && wr_req) owner = last_wr ? 1 : 2;
         else if (rd_req)      owner = 1;
         else if (wr_req)      owner = 2;
         beats = 0;
      end else begin
         mine   = (owner == 1) ? rd_req : wr_req;
         theirs = (owner == 1) ? wr_req : rd_req;
         if (quiet) begin
            quiet = 0;
            if (theirs) owner = 3 - owner;
            else if (!mine) owner = 0;
         end else if (!mine || beats == BURST_LEN - 1) begin
            last_wr = (owner == 2);
            beats   = 0;
            if (theirs) owner = 3 - owner;
            else if (!mine) owner = 0;
            else quiet = 1;
         end else begin
            beats++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rd_req = 0; wr_req = 0; rd_addr = '0; wr_addr = '0; wr_data = '0;
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
   endtask

   initial begin
      bit g;
      int cnt;
      int found;
      for (int i = 0; i < 256; i++) begin
         bram_mem[i] = 8'h00;
         ref_mem[i]  = 8'h00;
      end
      do_reset();
      for (int c = 0; c < 3; c++) cycle();

      // Single reader: 16-beat burst, one quiet beat, remaining 4 beats.
      do_reset();
      cnt = 0;
      for (int c = 0; c < 24; c++) begin
         rd_req  = (cnt < 20);
         rd_addr = ADDR_W'(cnt);
         cycle();
         g = (c >= 1 && c <= 16) || (c >= 18 && c <= 21);
         check("r20_gnt", 64'(s_rd_gnt), 64'(g));
         if (g) check("r20_addr", 64'(s_addr), 64'((c <= 16) ? c - 1 : c - 2));
         if (m_rd_gnt) cnt++;
      end
      rd_req = 0;

      // Both requesting: alternating 16-beat bursts, reader first.
      do_reset();
      rd_req = 1; wr_req = 1;
      for (int c = 0; c < 65; c++) begin
         rd_addr = ADDR_W'($urandom_range(255));
         wr_addr = ADDR_W'($urandom_range(255));
         wr_data = DATA_W'($urandom);
         cycle();
         check("alt_rd", 64'(s_rd_gnt), 64'((c >= 1 && c <= 16) || (c >= 33 && c <= 48)));
         check("alt_wr", 64'(s_wr_gnt), 64'((c >= 17 && c <= 32) || (c >= 49 && c <= 64)));
      end

      // Write 0xA5 to 100, then read it back.
      do_reset();
      wr_req = 1; wr_addr = ADDR_W'(100); wr_data = 8'hA5;
      found = 0;
      for (int c = 0; c < 8 && found == 0; c++) begin
         cycle();
         if (s_wr_gnt) begin
            found = 1;
            check("wb_wea", 64'(s_wea), 64'd1);
            check("wb_addr", 64'(s_addr), 64'd100);
         end
      end
      if (found == 0) check("wb_wgnt_timeout", 64'd0, 64'd1);
      wr_req = 0; rd_req = 1; rd_addr = ADDR_W'(100);
      found = 0;
      for (int c = 0; c < 8 && found == 0; c++) begin
         cycle();
         if (s_rd_gnt) found = 1;
      end
      if (found == 0) check("wb_rgnt_timeout", 64'd0, 64'd1);
      rd_req = 0;
      cycle();
      cycle();
      check("wb_valid", 64'(s_rd_valid), 64'd1);
      check("wb_data", 64'(s_rd_data), 64'hA5);

      // Reader drops after 3 beats while writer waits.
      do_reset();
      rd_req = 1; wr_req = 1; wr_addr = ADDR_W'(7); wr_data = 8'h3C;
      cnt = 0;
      for (int c = 0; c < 10 && cnt < 3; c++) begin
         rd_addr = ADDR_W'(cnt);
         cycle();
         if (m_rd_gnt) cnt++;
      end
      rd_req = 0;
      cycle();
      check("drop_nogrant", 64'(s_wr_gnt | s_rd_gnt), 64'd0);
      cycle();
      check("drop_wr", 64'(s_wr_gnt), 64'd1);
      check("drop_ret3", 64'(s_rd_valid), 64'd1);
      for (int c = 0; c < 3; c++) cycle();

      // Reset pulsed mid-read-burst.
      do_reset();
      rd_req = 1;
      for (int c = 0; c < 5; c++) begin
         rd_addr = ADDR_W'(c);
         cycle();
      end
      #3 rst = 1'b1;
      #1;
      check("rst_ena", 64'(ena_o), 64'd0);
      check("rst_rgnt", 64'(rd_gnt_o), 64'd0);
      check("rst_valid", 64'(rd_valid_o), 64'd0);
      check("rst_addr", 64'(addr_o), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      wr_req = 1; rd_req = 1;
      cycle();
      cycle();
      check("rst_tie_rd", 64'(s_rd_gnt), 64'd1);

      // Random traffic.
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(3) == 0) rd_req = ~rd_req;
         if ($urandom_range(3) == 0) wr_req = ~wr_req;
         if (m_rd_gnt) rd_addr = ADDR_W'($urandom_range(255));
         if (m_wr_gnt) begin
            wr_addr = ADDR_W'($urandom_range(255));
            wr_data = DATA_W'($urandom);
         end
         cycle();
      end

`ifdef BRAM_ARBITER_STATS_EN
      do_reset();
      cnt = 0;
      rd_req = 1;
      for (int c = 0; c < 100 && cnt < 37; c++) begin
         cycle();
         if (m_rd_gnt) cnt++;
      end
      rd_req = 0; wr_req = 1;
      cnt = 0;
      for (int c = 0; c < 100 && cnt < 5; c++) begin
         cycle();
         if (m_wr_gnt) cnt++;
      end
      wr_req = 0;
      cycle();
      check("stats_rd", 64'(rd_beats_o), 64'd37);
      check("stats_wr", 64'(wr_beats_o), 64'd5);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 19, BRAM address width; DATA_W, default 8, BRAM data width; BURST_LEN, default 16, maximum consecutive beats granted to one requester.
REQ-002 Ports SHALL be, one per line:
  clk  in  1  clock, all logic on rising edge
  rst  in  1  reset, asynchronous, active-high
  rd_req_i  in  1  fetch side requests a read beat
  rd_addr_i  in  ADDR_W  read address, held while rd_req_i high and not granted
  rd_gnt_o  out  1  read beat issued to BRAM this cycle
  rd_data_o  out  DATA_W  read data, 0 when rd_valid_o low
  rd_valid_o  out  1  rd_data_o valid, 2 cycles after matching rd_gnt_o
  wr_req_i  in  1  writeback side requests a write beat
  wr_addr_i  in  ADDR_W  write address
  wr_data_i  in  DATA_W  write data
  wr_gnt_o  out  1  write beat issued to BRAM this cycle
  ena_o  out  1  BRAM enable
  wea_o  out  1  BRAM write enable
  addr_o  out  ADDR_W  BRAM address
  d2mem_o  out  DATA_W  BRAM write data
  mem2d_i  in  DATA_W  BRAM read data, 2-cycle latency

Function
REQ-003 FSM states SHALL be IDLE, RD, WR; at most one BRAM access per cycle.
REQ-004 In IDLE no grant SHALL be issued; if exactly one requester is active, next state is its state; if both are active, next state serves the requester not served last (round-robin, last_wr flag).
REQ-005 In RD, rd_gnt_o SHALL equal rd_req_i combinationally; on grant, ena_o=1, wea_o=0, addr_o=rd_addr_i, d2mem_o=0.
REQ-006 In WR, wr_gnt_o SHALL equal wr_req_i combinationally; on grant, ena_o=1, wea_o=1, addr_o=wr_addr_i, d2mem_o=wr_data_i.
REQ-007 With no grant, ena_o, wea_o, addr_o and d2mem_o SHALL be 0.
REQ-008 A beat counter SHALL count grants in the current state, cleared on every state change.
REQ-009 Burst end: the burst ends when the counter reaches BURST_LEN-1 on a grant, or when the owner's req is low; at burst end the FSM SHALL go directly to the other state if the other requester is active, else to IDLE if the owner's req is low, else stay in the same state with the counter cleared.
REQ-010 last_wr SHALL update at each burst end to the state that just ended.
REQ-011 rd_valid_o SHALL be rd_gnt_o delayed exactly 2 cycles; rd_data_o=mem2d_i when rd_valid_o is high, else 0.
REQ-012 The read-return pipeline SHALL be independent of the FSM, so reads granted before an RD->WR switch still return in order 2 cycles later.
REQ-013 A requester SHALL never be granted while its req is low; the two grants are mutually exclusive.
REQ-014 Worst-case wait for an active requester SHALL be BURST_LEN+1 cycles.

Reset
REQ-015 Asserting rst SHALL immediately force state=IDLE, beat counter=0, last_wr=1 (so read wins the first tie), and the read-valid pipeline=0.
REQ-016 During and after reset, all outputs SHALL be 0 until the first grant; a reset mid-burst SHALL drop all in-flight rd_valid_o.

Configuration
REQ-017 Macro BRAM_ARBITER_STATS_EN: when defined, add outputs rd_beats_o[31:0] and wr_beats_o[31:0], which count grants, wrap at 2^32 and reset to 0; when undefined, neither the ports nor the counters exist and behaviour is otherwise identical.

Structure
REQ-018 Shared package bram_pkg SHALL hold the FSM state enum (IDLE=0, RD=1, WR=2), BRAM_RD_LATENCY=2, and the default ADDR_W and DATA_W.
REQ-019 The 2-stage read-valid/data delay SHALL be a sub-module named bram_rd_pipe; the FSM stays in bram_arbiter.

Verification
REQ-020 Read only: rd_req held for 20 cycles with addresses 0..19 -> IDLE for 1 cycle, then grants for addresses 0..15, 1 re-arm cycle, grants for 16..19; rd_valid_o follows each grant by 2 cycles.
REQ-021 Both requesting from reset -> RD first for 16 beats, then WR for 16 beats, alternating with no IDLE cycle between bursts.
REQ-022 Write of 0xA5 to address 100 followed by a read of address 100 -> wea_o=1 with addr_o=100 on the write grant; rd_data_o=0xA5 with rd_valid_o 2 cycles after the read grant.
REQ-023 rd_req dropped after 3 beats while wr_req is high -> the next cycle is WR, and the 3 read returns complete during the WR burst.
REQ-024 rst pulsed mid-RD-burst -> outputs become 0 asynchronously, pending rd_valid_o is suppressed, and the first grant after release is read on a tie.
REQ-025 With BRAM_ARBITER_STATS_EN defined, 37 reads and 5 writes -> rd_beats_o=37 and wr_beats_o=5.
